exec_mem_unit: RTL
==================

Name: exec_mem_unit

Overview:
- Parametrised, registered successor to the processor's combinational operand-select/add-sub stage.
- Accepts one instruction per handshake and computes either an ALU result or an effective memory address.
- For LOAD/STORE it runs the data-memory request/acknowledge transaction itself, with a timeout.
- Sits between register-file read and write-back; presents one result with valid/ready and write-back enable.

Parameters:
- DATA_W, 64, width of operands, offset, result and memory data.
- ADDR_W, 32, width of mem_addr; low ADDR_W bits of the effective address.
- ALIGN_LG2, 3, log2 of the required access alignment in bytes (0 disables the check).
- TIMEOUT, 255, max cycles waiting for mem_ack before abort (1..2^16-1).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  unit can accept
- op_sel  in  2  00 ALU reg-reg, 01 LOAD, 10 STORE, 11 ALU reg-imm
- add_sub  in  1  0 add, 1 subtract (ALU ops only; addresses always add)
- din_a  in  DATA_W  Ra value (base for LOAD/STORE)
- din_b  in  DATA_W  Rb value (store data for STORE)
- offset  in  DATA_W  sign-extended immediate
- mem_req  out  1  memory request
- mem_we  out  1  1 write, 0 read
- mem_addr  out  ADDR_W  effective address
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  transaction complete; mem_rdata valid same cycle
- mem_rdata  in  DATA_W  load data
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- out_data  out  DATA_W  ALU result or load data; 0 for STORE/error
- out_wb  out  1  write result to Rd (ALU, successful LOAD)
- out_zero  out  1  out_data == 0
- out_ovf  out  1  signed overflow of ALU op; 0 otherwise
- out_err  out  2  00 ok, 01 misaligned, 10 timeout

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - State IDLE.
  - All outputs 0 except in_ready=1.
  - Timeout counter 0.
- States:
  - IDLE: in_ready=1.
  - MEM: mem_req=1.
  - RESP: out_valid=1.
- Accept: in_valid & in_ready at a clock edge. Inputs are sampled only then and are don't-care otherwise.
- Arithmetic:
  - Modular DATA_W-bit arithmetic.
  - Sub = a + ~b + 1.
  - out_ovf = operand signs agree (after inversion for sub) and differ from the result sign.
  - Effective address = din_a + offset, truncated to ADDR_W.
- ALU accept (00: a±b; 11: a±offset) -> RESP next cycle, latency 1, out_wb=1.
- LOAD/STORE accept:
  - Misaligned address (low ALIGN_LG2 bits ≠ 0) -> RESP next cycle, out_err=01, out_wb=0, no mem_req.
  - Otherwise -> MEM next cycle. mem_addr, mem_we and mem_wdata are registered and stable while mem_req=1.
- MEM:
  - mem_req held high until mem_ack.
  - On mem_ack: mem_req=0 next cycle; LOAD latches mem_rdata; -> RESP. LOAD sets out_wb=1; STORE sets out_wb=0 and out_data=0.
  - Counter increments each MEM cycle without ack. At TIMEOUT cycles: drop mem_req, -> RESP with out_err=10, out_wb=0.
  - mem_ack in the same cycle as the counter reaching TIMEOUT: ack wins.
  - mem_ack outside MEM is ignored.
- RESP:
  - Outputs held stable until out_ready.
  - in_ready = out_ready, so back-to-back ALU ops sustain 1 per cycle.
  - out_ready & in_valid: next instruction is accepted at the same edge; no bubble.
  - out_ready without new input -> IDLE.
- Reset mid-MEM: mem_req drops immediately (async); the transaction is abandoned with no output.
- out_zero is computed from the registered out_data.

Decomposition:
- Shared package exec_mem_pkg:
  - op_sel encodings OP_ALU_RR, OP_LOAD, OP_STORE, OP_ALU_RI.
  - err encodings ERR_NONE, ERR_ALIGN, ERR_TIMEOUT.
  - State enum IDLE/MEM/RESP.
- One sub-module, addsub_ovf: parametrised DATA_W combinational add/sub with overflow flag, reused for the ALU path. The address adder is a plain add.

Test Plan:
- ALU:
  - op 00, add_sub=1, a=5, b=7, out_ready=1 -> out_valid 1 cycle later.
  - Checks: out_data=0xFFFF_FFFF_FFFF_FFFE, out_ovf=0, out_wb=1, out_zero=0.
  - Then op 11, a=0x7FFF_FFFF_FFFF_FFFF, offset=1, add -> out_data=0x8000_0000_0000_0000, out_ovf=1.
- LOAD:
  - op 01, a=0x1000, offset=0x18; ack after 3 cycles with rdata=0xDEAD.
  - Checks: mem_req high 3 cycles, mem_addr=0x1018, mem_we=0.
  - Then out_data=0xDEAD, out_wb=1, out_err=00.
- STORE misaligned: op 10, a=0x1001, offset=0 -> mem_req never asserts; out_err=01, out_wb=0.
- Timeout:
  - TIMEOUT=4, STORE a=0x2000, b=0x55, ack never -> mem_req high exactly 4 cycles, mem_wdata=0x55, then out_err=10.
  - Repeat with ack on the 4th cycle -> out_err=00.
- Backpressure/throughput:
  - out_ready=0 for 5 cycles -> outputs stable and in_ready=0.
  - Then 4 back-to-back ALU ops with out_ready=1 -> 4 results on 4 consecutive cycles, in order.
- Reset: assert rst_n=0 mid-MEM -> mem_req and out_valid drop asynchronously; after release in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/exec_mem_pkg.sv
// ----------------------------------------------------------------------------
// exec_mem_pkg
//   Shared encodings and types for the execute/memory unit.
//   - op_sel encodings (ALU reg-reg, LOAD, STORE, ALU reg-imm)
//   - out_err encodings (ok, misaligned, timeout)
//   - control state enumeration
//   - width of the memory acknowledge timeout counter
// ----------------------------------------------------------------------------
package exec_mem_pkg;

  localparam logic [1:0] OP_ALU_RR = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [1:0] OP_ALU_RI = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Counter is wide enough for the largest legal TIMEOUT (2^16-1).
  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    RESP = 2'd2
  } state_t;

  // True for the two op_sel codes that touch data memory.
  function automatic logic is_mem_op(input logic [1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/exec_mem_unit_addsub.sv
// ----------------------------------------------------------------------------
// addsub_ovf
//   Combinational DATA_W-bit modular adder/subtractor with signed overflow.
//   Subtraction is a + ~b + 1.
//   Ports:
//     a, b  in   operands
//     sub   in   0 add, 1 subtract
//     sum   out  modular result
//     ovf   out  signed overflow: effective operand signs agree and the
//                result sign differs from them
// ----------------------------------------------------------------------------
module addsub_ovf #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              ovf
);

  logic [DATA_W-1:0] b_eff;

  always_comb begin
    b_eff = sub ? ~b : b;
    // The carry-in of 1 completes the two's complement negation of b.
    sum   = a + b_eff + {{(DATA_W-1){1'b0}}, sub};
    ovf   = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
  end

endmodule

// File: rtl/exec_mem_unit.sv
// ----------------------------------------------------------------------------
// exec_mem_unit
//   Registered execute stage between register-file read and write-back.
//   Accepts one instruction per in_valid/in_ready handshake and produces
//   either an ALU result or, for LOAD/STORE, runs a data-memory
//   request/acknowledge transaction with a timeout. One result is presented
//   per instruction with out_valid/out_ready.
//
//   Ports:
//     clk, rst_n          clock (rising edge), async active-low reset
//     in_valid/in_ready   instruction handshake
//     op_sel, add_sub     operation select, add/subtract for ALU ops
//     din_a, din_b        Ra (base address) and Rb (store data) values
//     offset              sign-extended immediate
//     mem_req/mem_we      memory request and write enable
//     mem_addr/mem_wdata  registered address and store data
//     mem_ack/mem_rdata   memory completion and load data
//     out_valid/out_ready result handshake
//     out_data            ALU result or load data (0 for STORE/error)
//     out_wb              write result to Rd
//     out_zero            out_data == 0 while a result is presented
//     out_ovf             signed overflow of the ALU op
//     out_err             00 ok, 01 misaligned, 10 timeout
// ----------------------------------------------------------------------------
module exec_mem_unit
  import exec_mem_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int ALIGN_LG2 = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op_sel,
  input  logic              add_sub,
  input  logic [DATA_W-1:0] din_a,
  input  logic [DATA_W-1:0] din_b,
  input  logic [DATA_W-1:0] offset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_wb,
  output logic              out_zero,
  output logic              out_ovf,
  output logic [1:0]        out_err
);

  // Low ALIGN_LG2 bits set; an all-zero mask disables the alignment check.
  localparam logic [DATA_W-1:0] ALIGN_MASK =
    DATA_W'((64'd1 << ALIGN_LG2) - 64'd1);
  localparam logic [CNT_W-1:0]  TIMEOUT_C  = CNT_W'(TIMEOUT);

  state_t            state_q,     state_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_wb_q,    out_wb_d;
  logic              out_ovf_q,   out_ovf_d;
  logic [1:0]        out_err_q,   out_err_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic              mem_we_q,    mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              is_load_q,   is_load_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_sum;
  logic              alu_ovf;
  logic [DATA_W-1:0] eff_addr;
  logic              misaligned;
  logic              accept;
  logic [CNT_W-1:0]  cnt_inc;

  // ALU second operand: Rb for reg-reg, the immediate for reg-imm.
  always_comb begin
    alu_b = (op_sel == OP_ALU_RI) ? offset : din_b;
  end

  addsub_ovf #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a   (din_a),
    .b   (alu_b),
    .sub (add_sub),
    .sum (alu_sum),
    .ovf (alu_ovf)
  );

  // Effective address always adds, independent of add_sub.
  always_comb begin
    eff_addr   = din_a + offset;
    misaligned = |(eff_addr & ALIGN_MASK);
    cnt_inc    = cnt_q + CNT_W'(1);
  end

  // In RESP the unit can take a new instruction exactly when the current
  // result is being consumed, which gives one ALU op per cycle.
  always_comb begin
    in_ready  = (state_q == IDLE) || ((state_q == RESP) && out_ready);
    accept    = in_valid && in_ready;
    mem_req   = (state_q == MEM);
    out_valid = (state_q == RESP);
    out_zero  = out_valid && (out_data_q == '0);
    out_data  = out_data_q;
    out_wb    = out_wb_q;
    out_ovf   = out_ovf_q;
    out_err   = out_err_q;
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
  end

  // Next-state and result computation. Result registers only change on
  // entering RESP, so they stay stable while out_valid waits for out_ready.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_wb_d    = out_wb_q;
    out_ovf_d   = out_ovf_q;
    out_err_d   = out_err_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    is_load_d   = is_load_q;
    cnt_d       = cnt_q;

    case (state_q)
      MEM: begin
        // An acknowledge on the final allowed cycle still completes normally.
        if (mem_ack) begin
          state_d    = RESP;
          out_data_d = is_load_q ? mem_rdata : '0;
          out_wb_d   = is_load_q;
          out_ovf_d  = 1'b0;
          out_err_d  = ERR_NONE;
          cnt_d      = '0;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_d    = RESP;
          out_data_d = '0;
          out_wb_d   = 1'b0;
          out_ovf_d  = 1'b0;
          out_err_d  = ERR_TIMEOUT;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      IDLE, RESP: begin
        if (accept) begin
          out_ovf_d = 1'b0;
          out_err_d = ERR_NONE;
          cnt_d     = '0;
          if (is_mem_op(op_sel)) begin
            if (misaligned) begin
              state_d    = RESP;
              out_data_d = '0;
              out_wb_d   = 1'b0;
              out_err_d  = ERR_ALIGN;
            end else begin
              state_d     = MEM;
              mem_addr_d  = eff_addr[ADDR_W-1:0];
              mem_we_d    = (op_sel == OP_STORE);
              mem_wdata_d = (op_sel == OP_STORE) ? din_b : '0;
              is_load_d   = (op_sel == OP_LOAD);
            end
          end else begin
            state_d    = RESP;
            out_data_d = alu_sum;
            out_wb_d   = 1'b1;
            out_ovf_d  = alu_ovf;
          end
        end else if ((state_q == RESP) && out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Asynchronous reset drops mem_req and
  // out_valid immediately, abandoning any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_wb_q    <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= ERR_NONE;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      is_load_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_wb_q    <= out_wb_d;
      out_ovf_q   <= out_ovf_d;
      out_err_q   <= out_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      is_load_q   <= is_load_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule
